// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single physical memory port of the pipelined LC-3b core between
// the instruction-fetch requester (I-side, reads only) and the data-access
// requester (D-side, LDR/STR reads and writes).
//
// Registered round-robin arbiter around a 4-state FSM. Only one transaction
// is outstanding at a time. Each completed transaction returns a single-cycle
// response pulse on the side that was served. Every output comes straight
// from a register, so there is no combinational input-to-output path.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous, active-high reset
//   i_read        I-side read request, held until i_resp
//   i_address     I-side address
//   i_rdata       I-side read data, valid when i_resp=1
//   i_resp        I-side completion pulse
//   d_read        D-side read request, held until d_resp
//   d_write       D-side write request, held until d_resp
//   d_address     D-side address
//   d_wdata       D-side write data
//   d_rdata       D-side read data, valid when d_resp=1 after a read
//   d_resp        D-side completion pulse
//   pmem_read     physical memory read strobe
//   pmem_write    physical memory write strobe
//   pmem_address  physical memory address
//   pmem_wdata    physical memory write data
//   pmem_rdata    physical memory read data
//   pmem_resp     physical memory done, single-cycle
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_last_grant_d;   // 1: D-side won the most recent grant
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              r_i_resp;
  logic              r_d_resp;

  logic              w_i_req;
  logic              w_d_req;
  logic              w_grant_i;
  logic              w_grant_d;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // Round-robin grant decision. It only feeds register inputs in IDLE, so it
  // never reaches an output combinationally.
  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (w_i_req && w_d_req) begin
      // Tie: the side that did not win last time. last_grant resets to D,
      // so the first tie after reset goes to I.
      w_grant_i = r_last_grant_d;
      w_grant_d = ~r_last_grant_d;
    end else begin
      w_grant_i = w_i_req;
      w_grant_d = w_d_req;
    end
  end

  // Single FSM block; all outputs are registered here.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others regardless of order.
  // NOTE: the wide data registers are reset too, because the outputs they
  // drive must read zero immediately after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_last_grant_d <= 1'b1;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_i_rdata      <= '0;
      r_d_rdata      <= '0;
      r_i_resp       <= 1'b0;
      r_d_resp       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            r_state        <= SERVE_I;
            r_last_grant_d <= 1'b0;
            r_addr         <= i_address;
            r_wdata        <= '0;
            r_pmem_read    <= 1'b1;
            r_pmem_write   <= 1'b0;
          end else if (w_grant_d) begin
            r_state        <= SERVE_D;
            r_last_grant_d <= 1'b1;
            r_addr         <= d_address;
            r_wdata        <= d_wdata;
            // Read and write together is resolved as a write.
            r_pmem_read    <= ~d_write;
            r_pmem_write   <= d_write;
          end
        end

        // Request inputs are not looked at while serving: the captured
        // address, data and op carry the transaction to completion.
        SERVE_I: begin
          if (pmem_resp) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_i_rdata    <= pmem_rdata;
            r_i_resp     <= 1'b1;
            r_state      <= DONE;
          end
        end

        SERVE_D: begin
          if (pmem_resp) begin
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            // Writes leave the last read data untouched.
            if (r_pmem_read) begin
              r_d_rdata <= pmem_rdata;
            end
            r_d_resp     <= 1'b1;
            r_state      <= DONE;
          end
        end

        // One-cycle response slot; new requests wait for IDLE.
        DONE: begin
          r_i_resp <= 1'b0;
          r_d_resp <= 1'b0;
          r_state  <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign i_rdata      = r_i_rdata;
  assign i_resp       = r_i_resp;
  assign d_rdata      = r_d_rdata;
  assign d_resp       = r_d_resp;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. Expected transactions are queued
// when a request is driven; a negedge monitor plays the physical memory,
// checks each strobe cycle against the queue head, and pops the entry when
// the response pulse appears, comparing side and read data against a model.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  typedef struct {
    bit                is_d;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    int                lat;
  } txn_t;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [LINE_W-1:0] JUNK  = {4{32'hDEAD_BEEF}};
  localparam logic [LINE_W-1:0] STRAY = {4{32'h0BAD_F00D}};

  int                errors = 0;
  int                checks = 0;
  txn_t              exp_q[$];
  txn_t              mon_cur;
  int                mon_cnt = 0;
  bit                prev_strobe = 1'b0;
  int                stray_cycles = 0;
  logic [LINE_W-1:0] mdl_i_rdata = '0;
  logic [LINE_W-1:0] mdl_d_rdata = '0;

  task automatic check(input string tag, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push_txn(input bit is_d, input bit wr, input logic [ADDR_W-1:0] addr,
                          input logic [LINE_W-1:0] wdata, input logic [LINE_W-1:0] rdata,
                          input int lat);
    txn_t t;
    t.is_d = is_d; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.lat = lat;
    exp_q.push_back(t);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_strobe(input int max_cycles);
    int n;
    n = 0;
    while (!(pmem_read || pmem_write) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("strobe_seen", pmem_read | pmem_write, 1'b1);
  endtask

  // Memory responder and scoreboard monitor.
  always @(negedge clk) begin
    bit resp_now;
    resp_now = 1'b0;
    if (rst) begin
      mon_cnt     = 0;
      prev_strobe = 1'b0;
      pmem_resp   = 1'b0;
      pmem_rdata  = JUNK;
    end else begin
      if (i_resp || d_resp) begin
        check("resp_after_strobe", prev_strobe, 1'b1);
        if (exp_q.size() == 0) begin
          check("spurious_resp", {i_resp, d_resp}, 2'b00);
        end else begin
          mon_cur = exp_q.pop_front();
          check("resp_side", {i_resp, d_resp}, mon_cur.is_d ? 2'b01 : 2'b10);
          if (!mon_cur.wr) begin
            if (mon_cur.is_d) mdl_d_rdata = mon_cur.rdata;
            else              mdl_i_rdata = mon_cur.rdata;
          end
          check("i_rdata", i_rdata, mdl_i_rdata);
          check("d_rdata", d_rdata, mdl_d_rdata);
        end
      end
      if (pmem_read || pmem_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {pmem_read, pmem_write}, 2'b00);
        end else begin
          mon_cur = exp_q[0];
          check("pmem_address", pmem_address, mon_cur.addr);
          check("pmem_op", {pmem_read, pmem_write}, mon_cur.wr ? 2'b01 : 2'b10);
          if (mon_cur.wr) check("pmem_wdata", pmem_wdata, mon_cur.wdata);
          if (mon_cur_over(mon_cnt, mon_cur.lat)) check("strobe_len", mon_cnt, mon_cur.lat - 1);
          if (mon_cnt == mon_cur.lat - 1) resp_now = 1'b1;
          mon_cnt++;
        end
      end else begin
        mon_cnt = 0;
      end
      prev_strobe = pmem_read | pmem_write;
      if (stray_cycles > 0) begin
        stray_cycles--;
        pmem_resp  = 1'b1;
        pmem_rdata = STRAY;
      end else begin
        pmem_resp  = resp_now;
        pmem_rdata = resp_now ? mon_cur.rdata : JUNK;
      end
    end
  end

  function automatic bit mon_cur_over(input int cnt, input int lat);
    return cnt >= lat;
  endfunction

  initial begin
    rst = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = JUNK;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_rdata", {i_rdata, d_rdata} == '0, 1'b1);
    check("rst_resp", {i_resp, d_resp}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // Tie from reset: I, D, I, D with single-cycle responder.
    push_txn(1'b0, 1'b0, 16'h0100, '0, {8{16'h1001}}, 1);
    push_txn(1'b1, 1'b0, 16'h0200, '0, {8{16'h2002}}, 1);
    push_txn(1'b0, 1'b0, 16'h0100, '0, {8{16'h3003}}, 1);
    push_txn(1'b1, 1'b0, 16'h0200, '0, {8{16'h4004}}, 1);
    i_address = 16'h0100; d_address = 16'h0200;
    i_read = 1'b1; d_read = 1'b1;
    wait_drain(60);
    i_read = 1'b0; d_read = 1'b0;
    repeat (2) @(negedge clk);

    // I read, memory answers on the third strobe cycle.
    push_txn(1'b0, 1'b0, 16'h0040, '0, {16{8'hA5}}, 3);
    i_address = 16'h0040; i_read = 1'b1;
    @(negedge clk);
    check("i_strobe_latency", pmem_read, 1'b1);
    wait_drain(40);
    i_read = 1'b0;
    check("i_rdata_a5", i_rdata, {16{8'hA5}});
    repeat (2) @(negedge clk);

    // D write with the address changed mid-serve.
    push_txn(1'b1, 1'b1, 16'h1230, {8{16'h1111}}, {8{16'hBEEF}}, 3);
    d_address = 16'h1230; d_wdata = {8{16'h1111}}; d_write = 1'b1;
    @(negedge clk);
    check("d_strobe_latency", pmem_write, 1'b1);
    d_address = 16'h9999; d_wdata = {8{16'h9999}};
    wait_drain(40);
    d_write = 1'b0;
    check("d_rdata_after_write", d_rdata, {8{16'h4004}});
    repeat (2) @(negedge clk);

    // Read and write together resolve to a write.
    push_txn(1'b1, 1'b1, 16'h3000, {4{32'h5555_AAAA}}, {8{16'hBEEF}}, 2);
    d_address = 16'h3000; d_wdata = {4{32'h5555_AAAA}};
    d_read = 1'b1; d_write = 1'b1;
    wait_drain(40);
    d_read = 1'b0; d_write = 1'b0;
    repeat (2) @(negedge clk);

    // Stray pmem_resp while idle.
    stray_cycles = 1;
    repeat (4) @(negedge clk);
    check("stray_no_strobe", {pmem_read, pmem_write}, 2'b00);
    check("stray_i_rdata", i_rdata, {16{8'hA5}});
    check("stray_d_rdata", d_rdata, {8{16'h4004}});

    // Reset in the middle of a D write.
    push_txn(1'b1, 1'b1, 16'h4444, {8{16'h7777}}, {8{16'hBEEF}}, 20);
    d_address = 16'h4444; d_wdata = {8{16'h7777}}; d_write = 1'b1;
    wait_strobe(10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_pmem_write", pmem_write, 1'b0);
    check("midrst_pmem_read", pmem_read, 1'b0);
    check("midrst_pmem_address", pmem_address, '0);
    check("midrst_pmem_wdata", pmem_wdata, '0);
    check("midrst_i_rdata", i_rdata, '0);
    check("midrst_d_rdata", d_rdata, '0);
    check("midrst_resp", {i_resp, d_resp}, 2'b00);
    exp_q.delete();
    mdl_i_rdata = '0; mdl_d_rdata = '0;
    d_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_idle", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical memory port between the instruction-fetch requester (I-side) and the data-access requester (D-side) of the pipelined LC-3b core.
- The D-side carries the LDR/STR traffic decoded by the control ROM.
- Registered round-robin arbiter with a 4-state FSM.
- One transaction outstanding at a time. Each port gets a single-cycle response pulse.

Parameters:
ADDR_W, 16, address width (lc3b_word).
LINE_W, 128, data width of one memory transfer (cache line).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
i_read  in  1  I-side read request, held until i_resp
i_address  in  ADDR_W  I-side address
i_rdata  out  LINE_W  I-side read data, valid when i_resp=1
i_resp  out  1  I-side completion pulse
d_read  in  1  D-side read request, held until d_resp
d_write  in  1  D-side write request, held until d_resp
d_address  in  ADDR_W  D-side address
d_wdata  in  LINE_W  D-side write data
d_rdata  out  LINE_W  D-side read data, valid when d_resp=1 after a read
d_resp  out  1  D-side completion pulse
pmem_read  out  1  physical memory read strobe
pmem_write  out  1  physical memory write strobe
pmem_address  out  ADDR_W  physical memory address
pmem_wdata  out  LINE_W  physical memory write data
pmem_rdata  in  LINE_W  physical memory read data
pmem_resp  in  1  physical memory done, single-cycle

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=D.
  - All outputs 0, including pmem_read/write, pmem_address, pmem_wdata, rdata registers and resp outputs.
  - Reset mid-transaction aborts it; pmem strobes drop without waiting for pmem_resp.
- States: IDLE, SERVE_I, SERVE_D, DONE. All outputs come from registers; no combinational path from inputs to outputs.
- IDLE: sample requests each edge.
  - Only I pending: go to SERVE_I.
  - Only D pending (d_read|d_write): go to SERVE_D.
  - Both pending: grant the side not equal to last_grant. The first tie after reset goes to I.
  - On grant, capture into registers: address, wdata, op, and last_grant := granted side.
- SERVE_x:
  - pmem_read/pmem_write=1 from the first SERVE cycle, so latency from the request-sampling edge to the strobe is 1 cycle.
  - Address and wdata are driven from the captured registers and stay stable for the whole transaction.
  - d_read and d_write both high: treated as a write.
  - Requester changes or drops its request mid-serve: ignored. The transaction completes and the response still pulses.
- pmem_resp=1 in SERVE_x:
  - Capture pmem_rdata into x_rdata (reads only).
  - Deassert pmem strobes at that edge.
  - Go to DONE.
- DONE (exactly 1 cycle):
  - x_resp=1 for the served side only; the other side's resp stays 0.
  - New requests are ignored during DONE. Next state is IDLE.
- x_rdata holds its value until the next read response on that same port. d_rdata is unchanged by writes.
- pmem_resp while in IDLE or DONE: ignored.
- Minimum transaction = 3 cycles: SERVE (with same-cycle pmem_resp), then DONE, then IDLE.
- A back-to-back request from the same side is sampled in the IDLE cycle after DONE.
- Fairness: under continuous requests from both sides, grants strictly alternate.

Test Plan:
- Reset then i_read=1, i_address=0x0040; pmem_resp on the 3rd SERVE cycle with pmem_rdata=0xA5..A5 -> pmem_read=1 with pmem_address=0x0040 for exactly 3 cycles; one cycle later i_resp=1 for 1 cycle with i_rdata=0xA5..A5; d_resp stays 0.
- d_write=1, d_address=0x1230, d_wdata=0x1111..; d_address changed to 0x9999 during SERVE -> pmem_write=1 with pmem_address=0x1230 and pmem_wdata=0x1111.. throughout; d_resp pulses once; d_rdata unchanged.
- i_read and d_read asserted together from reset and held, responder answers in 1 cycle -> grant order I, D, I, D; each pmem_address matches the granted side; no two resp pulses in the same cycle.
- d_read and d_write both asserted -> pmem_write=1 and pmem_read=0.
- Assert rst while SERVE_D is active with pmem_write=1 -> all outputs 0 before the next clk edge; after release with no requests, FSM stays IDLE and no resp is generated.
- pmem_resp pulsed while IDLE with no requests -> no resp output and no state change; x_rdata keeps its prior value.
